obstacle_alert_ctrl: RTL

- Parametrised N-channel obstacle alert controller for the buzzer front-end.
- Each proximity sensor input is synchronised and debounced, then drives a 2-bit alert level that escalates the longer the obstacle persists.
- An optional, compiled-in generator turns each level into a buzzer pulse pattern.
- Sits between the raw `ui_in` sensor pins and the `uo_out` buzzer pins in the top-level wrapper.

---
 rtl/obstacle_alert_ctrl_if.sv | 27 ++
 rtl/obstacle_alert_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/obstacle_alert_ctrl_if.sv
// obstacle_alert_ctrl_if
//   Groups the sensor/buzzer-side signals of obstacle_alert_ctrl.
//   sensor_in  : raw asynchronous sensor lines, 1 = obstacle
//   mute       : synchronous buzzer mute
//   level      : channel i alert level on bits [2i+1:2i]
//   buzz_pulse : per-channel buzzer drive
//   any_alert  : OR of all debounced detect states
//   master modport drives sensor_in/mute; slave modport (the controller) drives the outputs.
interface obstacle_alert_ctrl_if #(
  parameter int unsigned N_CH = 2
);
  logic [N_CH-1:0]   sensor_in;
  logic              mute;
  logic [2*N_CH-1:0] level;
  logic [N_CH-1:0]   buzz_pulse;
  logic              any_alert;

  modport master (
    output sensor_in, mute,
    input  level, buzz_pulse, any_alert
  );

  modport slave (
    input  sensor_in, mute,
    output level, buzz_pulse, any_alert
  );
endinterface

// File: rtl/obstacle_alert_ctrl.sv
// obstacle_alert_ctrl
//   N-channel obstacle alert controller. Each sensor line is synchronised
//   (two flops), debounced, and drives a 2-bit alert level that escalates
//   every ESC_CYCLES cycles of continuous detection up to 3.
//   Ports:
//     clk   : single clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : obstacle_alert_ctrl_if.slave (sensor_in, mute, level,
//             buzz_pulse, any_alert)
//   Optional feature macro: OBST_PATTERN_EN
//     defined   : shared prescaler + 3-bit phase turn each level into a
//                 buzzer pattern (off / 1-of-8 / 50 % / continuous)
//     undefined : buzz_pulse = registered (level != 0) & !mute
module obstacle_alert_ctrl #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned ESC_CYCLES = 1000,
  parameter int unsigned TICK_DIV   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  obstacle_alert_ctrl_if.slave bus
);

  if (N_CH < 1 || N_CH > 4 || DEB_CYCLES < 2 || ESC_CYCLES < 2 || TICK_DIV < 2) begin : g_bad_param
    $error("obstacle_alert_ctrl: parameter out of range");
  end

  localparam int unsigned DCW = $clog2(DEB_CYCLES);
  localparam int unsigned ECW = $clog2(ESC_CYCLES);

  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [ECW-1:0] ECNT_LAST = ECW'(ESC_CYCLES - 1);

  typedef enum logic [1:0] {
    LVL_0 = 2'd0,
    LVL_1 = 2'd1,
    LVL_2 = 2'd2,
    LVL_3 = 2'd3
  } level_e;

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [N_CH-1:0] deb_q,   deb_d;
  logic [DCW-1:0]  dcnt_q [N_CH];
  logic [DCW-1:0]  dcnt_d [N_CH];
  logic [ECW-1:0]  ecnt_q [N_CH];
  logic [ECW-1:0]  ecnt_d [N_CH];
  level_e          lvl_q  [N_CH];
  level_e          lvl_d  [N_CH];
  logic [N_CH-1:0] buzz_q,  buzz_d;
  logic            any_alert_q, any_alert_d;

  // Synchroniser, debounce and level escalation
  always_comb begin
    sync1_d = bus.sensor_in;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      dcnt_d[i] = dcnt_q[i];
      ecnt_d[i] = ecnt_q[i];
      lvl_d[i]  = lvl_q[i];

      // Any sample agreeing with deb restarts the count, so only an
      // unbroken run of DEB_CYCLES differing samples flips deb.
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DCNT_LAST) begin
          deb_d[i]  = sync2_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DCW'(1);
        end
      end else begin
        dcnt_d[i] = '0;
      end

      if (!deb_q[i]) begin
        lvl_d[i]  = LVL_0;
        ecnt_d[i] = '0;
      end else begin
        unique case (lvl_q[i])
          LVL_0: begin
            lvl_d[i]  = LVL_1;
            ecnt_d[i] = '0;
          end
          LVL_1, LVL_2: begin
            if (ecnt_q[i] == ECNT_LAST) begin
              lvl_d[i]  = (lvl_q[i] == LVL_1) ? LVL_2 : LVL_3;
              ecnt_d[i] = '0;
            end else begin
              ecnt_d[i] = ecnt_q[i] + ECW'(1);
            end
          end
          LVL_3: begin
            ecnt_d[i] = '0;
          end
          default: begin
            lvl_d[i]  = LVL_0;
            ecnt_d[i] = '0;
          end
        endcase
      end
    end
    any_alert_d = |deb_q;
  end

`ifdef OBST_PATTERN_EN
  localparam int unsigned PCW = $clog2(TICK_DIV);
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(TICK_DIV - 1);

  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [2:0]     phase_q, phase_d;
  logic           tick;

  always_comb begin
    tick    = (pcnt_q == PCNT_LAST);
    pcnt_d  = tick ? '0 : pcnt_q + PCW'(1);
    phase_d = tick ? phase_q + 3'd1 : phase_q;
    buzz_d  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      unique case (lvl_q[i])
        LVL_0:   buzz_d[i] = 1'b0;
        LVL_1:   buzz_d[i] = (phase_q == 3'd0);
        LVL_2:   buzz_d[i] = phase_q[0];
        LVL_3:   buzz_d[i] = 1'b1;
        default: buzz_d[i] = 1'b0;
      endcase
    end
    if (bus.mute) begin
      buzz_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q  <= '0;
      phase_q <= '0;
    end else begin
      pcnt_q  <= pcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  always_comb begin
    buzz_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      buzz_d[i] = (lvl_q[i] != LVL_0) && !bus.mute;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      buzz_q      <= '0;
      any_alert_q <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        dcnt_q[i] <= '0;
        ecnt_q[i] <= '0;
        lvl_q[i]  <= LVL_0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      buzz_q      <= buzz_d;
      any_alert_q <= any_alert_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        ecnt_q[i] <= ecnt_d[i];
        lvl_q[i]  <= lvl_d[i];
      end
    end
  end

  always_comb begin
    bus.level = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      bus.level[2*i +: 2] = lvl_q[i];
    end
    bus.buzz_pulse = buzz_q;
    bus.any_alert  = any_alert_q;
  end

endmodule
